// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and RUN/HALT debug FSM.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_if,
    input  logic             stall_id,
    input  logic             flush_id,
    input  logic             npc_sel,
    input  logic [31:0]      npc_target,
    input  logic             ebreak_id,
    input  logic             resume,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc_if,
    output logic [31:0]      pc_id,
    output logic [31:0]      pcadd4_id,
    output logic [31:0]      inst_id,
    output logic             valid_id,
    output logic             halted,
    output logic [CNT_W-1:0] perf_fetch,
    output logic [CNT_W-1:0] perf_flush
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] pcadd4_id_q, pcadd4_id_d;
    logic [31:0] inst_id_q, inst_id_d;
    logic        valid_id_q, valid_id_d;
    logic        halt_go;
    logic        load_id;

    // Only a live, non-squashed ebreak in ID may halt the core.
    assign halt_go = (state_q == StRun) & ebreak_id & valid_id_q & ~stall_id & ~flush_id
                   & ~npc_sel;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (halt_go) state_d = StHalt;
            StHalt:  if (resume) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (npc_sel) begin
            pc_d = {npc_target[31:2], 2'b00};
        end else if (!((state_q == StHalt) || halt_go || stall_if)) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_comb begin
        pc_id_d     = pc_id_q;
        pcadd4_id_d = pcadd4_id_q;
        inst_id_d   = inst_id_q;
        valid_id_d  = valid_id_q;
        load_id     = 1'b0;
        if (flush_id) begin
            inst_id_d  = NOP_INST;
            valid_id_d = 1'b0;
        end else if (stall_id) begin
            valid_id_d = valid_id_q;
        end else if ((state_q == StHalt) || halt_go) begin
            inst_id_d  = NOP_INST;
            valid_id_d = 1'b0;
        end else begin
            pc_id_d     = pc_q;
            pcadd4_id_d = pc_q + 32'd4;
            inst_id_d   = imem_rdata;
            valid_id_d  = 1'b1;
            load_id     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            pc_q        <= PC_RESET;
            pc_id_q     <= 32'd0;
            pcadd4_id_q <= 32'd0;
            inst_id_q   <= NOP_INST;
            valid_id_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_id_q     <= pc_id_d;
            pcadd4_id_q <= pcadd4_id_d;
            inst_id_q   <= inst_id_d;
            valid_id_q  <= valid_id_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] perf_fetch_q, perf_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (load_id) perf_fetch_q <= perf_fetch_q + 1'b1;
            if (flush_id && valid_id_q) perf_flush_q <= perf_flush_q + 1'b1;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_flush = perf_flush_q;
`else
    logic unused_load;
    assign unused_load = load_id;
    assign perf_fetch  = '0;
    assign perf_flush  = '0;
`endif

    assign imem_addr = pc_q;
    assign pc_if     = pc_q;
    assign pc_id     = pc_id_q;
    assign pcadd4_id = pcadd4_id_q;
    assign inst_id   = inst_id_q;
    assign valid_id  = valid_id_q;
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random stimulus against
// a behavioural pipeline model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst;
    logic        stall_if, stall_id, flush_id, npc_sel, ebreak_id, resume;
    logic [31:0] npc_target, imem_addr, imem_rdata;
    logic [31:0] pc_if, pc_id, pcadd4_id, inst_id;
    logic        valid_id, halted;
    logic [31:0] perf_fetch, perf_flush;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_pc_id, m_pc4, m_inst;
    logic        m_valid, m_halted;
    logic [31:0] m_nfetch, m_nflush;

    if_stage dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .npc_sel(npc_sel), .npc_target(npc_target),
        .ebreak_id(ebreak_id), .resume(resume), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc_if(pc_if), .pc_id(pc_id), .pcadd4_id(pcadd4_id),
        .inst_id(inst_id), .valid_id(valid_id), .halted(halted),
        .perf_fetch(perf_fetch), .perf_flush(perf_flush)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F69;
    endfunction

    assign imem_rdata = mem(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_3000; m_pc_id = '0; m_pc4 = '0; m_inst = NOP;
        m_valid = 1'b0; m_halted = 1'b0; m_nfetch = '0; m_nflush = '0;
    endtask

    // One clock edge of the fetch stage, written from the stage's priority rules.
    task automatic model_edge();
        logic go;
        go = !m_halted && ebreak_id && m_valid && !stall_id && !flush_id && !npc_sel;
        if (flush_id) begin
            if (m_valid) m_nflush++;
            m_inst = NOP; m_valid = 1'b0;
        end else if (stall_id) begin
            // IF/ID holds
        end else if (m_halted || go) begin
            m_inst = NOP; m_valid = 1'b0;
        end else begin
            m_pc_id = m_pc; m_pc4 = m_pc + 32'd4; m_inst = mem(m_pc); m_valid = 1'b1;
            m_nfetch++;
        end
        if (npc_sel) m_pc = npc_target & 32'hFFFF_FFFC;
        else if (!(m_halted || go || stall_if)) m_pc = m_pc + 32'd4;
        if (go) m_halted = 1'b1;
        else if (m_halted && resume) m_halted = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc_if"}, pc_if, m_pc);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".pc_id"}, pc_id, m_pc_id);
        chk({tag, ".pcadd4_id"}, pcadd4_id, m_pc4);
        chk({tag, ".inst_id"}, inst_id, m_inst);
        chk({tag, ".valid_id"}, {31'd0, valid_id}, {31'd0, m_valid});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
`ifdef FETCH_PERF_EN
        chk({tag, ".perf_fetch"}, perf_fetch, m_nfetch);
        chk({tag, ".perf_flush"}, perf_flush, m_nflush);
`else
        chk({tag, ".perf_fetch"}, perf_fetch, 32'd0);
        chk({tag, ".perf_flush"}, perf_flush, 32'd0);
`endif
    endtask

    task automatic idle();
        stall_if = 0; stall_id = 0; flush_id = 0; npc_sel = 0; ebreak_id = 0; resume = 0;
        npc_target = '0;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // the edge right after release counts as a normal fetch edge
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #1;
        rst = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        chk("reset.pc_const", pc_if, 32'h0000_3000);
        chk("reset.inst_const", inst_id, NOP);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Free run: 0x3000 -> 0x3004 -> 0x3008
        step("run1");
        chk("run1.pc_id_const", pc_id, 32'h0000_3000);
        chk("run1.pcadd4_const", pcadd4_id, 32'h0000_3004);
        chk("run1.inst_const", inst_id, mem(32'h0000_3000));
        step("run2");
        chk("run2.pc_const", pc_if, 32'h0000_3008);

        // Full stall for 3 cycles at 0x3008
        stall_if = 1; stall_id = 1;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall.pc_const", pc_if, 32'h0000_3008);
        idle();
        step("unstall1");
        chk("unstall1.pc_const", pc_if, 32'h0000_300C);
        chk("unstall1.pc_id_const", pc_id, 32'h0000_3008);

        // Redirect with flush, redirect beats stall_if
        npc_sel = 1; npc_target = 32'h0000_3043; flush_id = 1; stall_if = 1;
        step("redir");
        chk("redir.pc_const", pc_if, 32'h0000_3040);
        chk("redir.valid_const", {31'd0, valid_id}, 32'd0);
        idle();
        step("redir_after");
        chk("redir_after.inst_const", inst_id, mem(32'h0000_3040));

        // Ebreak at 0x3010 halts the core
        rst = 1'b1; model_reset(); #1; check_all("reset2");
        @(negedge clk); rst = 1'b0; #1;
        for (int i = 0; i < 5; i++) step("pre_ebreak");
        chk("pre_ebreak.pc_id_const", pc_id, 32'h0000_3010);
        ebreak_id = 1;
        step("ebreak");
        chk("ebreak.halted_const", {31'd0, halted}, 32'd1);
        chk("ebreak.pc_const", pc_if, 32'h0000_3014);
        ebreak_id = 0;
        for (int i = 0; i < 10; i++) step("halt_hold");
        chk("halt_hold.pc_const", pc_if, 32'h0000_3014);
        resume = 1;
        step("resume");
        chk("resume.halted_const", {31'd0, halted}, 32'd0);
        resume = 0;
        step("resume_fetch");
        chk("resume_fetch.inst_const", inst_id, mem(32'h0000_3014));

        // Squashed ebreak never halts
        ebreak_id = 1; npc_sel = 1; flush_id = 1; npc_target = 32'h0000_3200;
        step("squash_ebreak");
        chk("squash_ebreak.halted_const", {31'd0, halted}, 32'd0);
        chk("squash_ebreak.pc_const", pc_if, 32'h0000_3200);
        idle();

        // Perf counters: 5 valid fetches then one flush of a valid entry
        rst = 1'b1; model_reset(); #1; check_all("reset3");
        @(negedge clk); rst = 1'b0; #1;
        for (int i = 0; i < 5; i++) step("perf_run");
        flush_id = 1; stall_if = 1;
        step("perf_flush");
        idle();
`ifdef FETCH_PERF_EN
        chk("perf.fetch_const", perf_fetch, 32'd5);
        chk("perf.flush_const", perf_flush, 32'd1);
`else
        chk("perf.fetch_zero", perf_fetch, 32'd0);
        chk("perf.flush_zero", perf_flush, 32'd0);
`endif

        // Random stimulus against the model, with occasional async reset
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                idle();
                rst = 1'b1; model_reset(); #1; check_all("rand_reset");
                #1; rst = 1'b0;
            end
            stall_if   = ($urandom_range(0, 5) == 0);
            stall_id   = ($urandom_range(0, 5) == 0);
            flush_id   = ($urandom_range(0, 7) == 0);
            npc_sel    = ($urandom_range(0, 9) == 0);
            npc_target = $urandom;
            ebreak_id  = ($urandom_range(0, 11) == 0);
            resume     = ($urandom_range(0, 3) == 0);
            step("rand");
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
